// File: rtl/comp_pkg.sv
// Shared widths and result type for the two-column 512-row counter.
// No logic; constants only.
package comp_pkg;
    localparam int COMP_COL_W   = 512;
    localparam int COMP_PC_W    = 10;
    localparam int COMP_OUT_W   = 11;
    localparam int COMP_MAX_SUM = 1536;

    typedef logic [COMP_OUT_W-1:0] comp_sum_t;
endpackage

// File: rtl/comp_popcount512.sv
// Combinational 512-bit ones counter: 6:3 counters, a word-level 3:2 carry-save tree, one final add.
// Latency: 0 cycles (pure combinational). Backpressure: none, no handshake.
// The counters only evaluate the data they are given; this block holds no state.
module comp_popcount512
    import comp_pkg::*;
(
    input  logic [COMP_COL_W-1:0] bits_i,
    output logic [COMP_PC_W-1:0]  count_o
);
    localparam int GRP    = 6;
    localparam int NG     = (COMP_COL_W + GRP - 1) / GRP;
    localparam int PAD_W  = NG * GRP;
    localparam int MAXLVL = 12;

    logic [PAD_W-1:0]     padded;
    logic [COMP_PC_W-1:0] heap [NG];
    logic [COMP_PC_W-1:0] nxt  [NG];

    assign padded = {{(PAD_W - COMP_COL_W){1'b0}}, bits_i};

    // The operand count n is data-independent, so every loop unrolls to a fixed CSA tree.
    always_comb begin
        int n;
        int ng;
        int rem;
        logic [2:0]           cnt6;
        logic [COMP_PC_W-1:0] a;
        logic [COMP_PC_W-1:0] b;
        logic [COMP_PC_W-1:0] c;

        for (int g = 0; g < NG; g++) begin
            cnt6 = 3'd0;
            for (int k = 0; k < GRP; k++) begin
                cnt6 = cnt6 + 3'(padded[g*GRP + k]);
            end
            heap[g] = {{(COMP_PC_W - 3){1'b0}}, cnt6};
            nxt[g]  = '0;
        end

        n = NG;
        for (int lvl = 0; lvl < MAXLVL; lvl++) begin
            if (n > 2) begin
                ng  = n / 3;
                rem = n - 3 * ng;
                for (int g = 0; g < NG; g++) begin
                    nxt[g] = '0;
                end
                for (int g = 0; g < NG / 3; g++) begin
                    if (g < ng) begin
                        a = heap[3*g];
                        b = heap[3*g + 1];
                        c = heap[3*g + 2];
                        nxt[2*g]     = a ^ b ^ c;
                        nxt[2*g + 1] = ((a & b) | (a & c) | (b & c)) << 1;
                    end
                end
                for (int r = 0; r < 2; r++) begin
                    if (r < rem) begin
                        nxt[2*ng + r] = heap[3*ng + r];
                    end
                end
                for (int g = 0; g < NG; g++) begin
                    heap[g] = nxt[g];
                end
                n = 2 * ng + rem;
            end
        end

        // Sum never exceeds 512, so modulo-2^10 carry-save arithmetic stays exact.
        count_o = heap[0] + heap[1];
    end
endmodule

// File: rtl/comp_double512_gpc.sv
// Two-column GPC: comp_out = popcount(in_col0) + 2*popcount(in_col1), registered.
// Latency 1 cycle (2 with COMP_DOUBLE512_IN_REG_EN defined); no backpressure, one result per cycle.
module comp_double512_gpc
    import comp_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [COMP_COL_W-1:0] in_col0,
    input  logic [COMP_COL_W-1:0] in_col1,
    output comp_sum_t             comp_out
);
    logic [COMP_COL_W-1:0] col0;
    logic [COMP_COL_W-1:0] col1;
    logic [COMP_PC_W-1:0]  pc0;
    logic [COMP_PC_W-1:0]  pc1;
    comp_sum_t             sum_d;
    comp_sum_t             sum_q;

`ifdef COMP_DOUBLE512_IN_REG_EN
    logic [COMP_COL_W-1:0] col0_q;
    logic [COMP_COL_W-1:0] col1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col0_q <= '0;
            col1_q <= '0;
        end else begin
            col0_q <= in_col0;
            col1_q <= in_col1;
        end
    end

    assign col0 = col0_q;
    assign col1 = col1_q;
`else
    assign col0 = in_col0;
    assign col1 = in_col1;
`endif

    comp_popcount512 u_pc0 (
        .bits_i  (col0),
        .count_o (pc0)
    );

    comp_popcount512 u_pc1 (
        .bits_i  (col1),
        .count_o (pc1)
    );

    // Weight-2 column enters the final adder pre-shifted; max 512 + 1024 fits 11 bits.
    assign sum_d = {1'b0, pc0} + {pc1, 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign comp_out = sum_q;
endmodule

// File: tb/tb_comp_double512_gpc.sv
// Directed and random bench for comp_double512_gpc in its default 1-cycle-latency build.
module tb_comp_double512_gpc;
    logic         clk;
    logic         rst_n;
    logic [511:0] in_col0;
    logic [511:0] in_col1;
    logic [10:0]  comp_out;

    int errors;
    int checks;

    comp_double512_gpc dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_col0  (in_col0),
        .in_col1  (in_col1),
        .comp_out (comp_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [10:0] model(input logic [511:0] c0, input logic [511:0] c1);
        int s;
        s = 0;
        for (int i = 0; i < 512; i++) s = s + int'(c0[i]) + 2 * int'(c1[i]);
        return 11'(s);
    endfunction

    task automatic test_reset();
        in_col0 = rnd512();
        in_col1 = rnd512();
        rst_n   = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (comp_out !== 11'd0) begin
            errors++;
            $display("FAIL reset_async: got %0d expected 0", comp_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (comp_out !== 11'd0) begin
            errors++;
            $display("FAIL reset_hold: got %0d expected 0", comp_out);
        end
        in_col0 = '1;
        in_col1 = '0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (comp_out !== 11'd512) begin
            errors++;
            $display("FAIL reset_release_first: got %0d expected 512", comp_out);
        end
    endtask

    task automatic test_patterns();
        logic [511:0] c0 [4];
        logic [511:0] c1 [4];
        logic [10:0]  exp_v [4];
        c0[0] = '0; c1[0] = '0; exp_v[0] = 11'd0;
        c0[1] = '1; c1[1] = '1; exp_v[1] = 11'h600;
        c0[2] = '1; c1[2] = '0; exp_v[2] = 11'd512;
        c0[3] = '0; c1[3] = '0; c1[3][511] = 1'b1; exp_v[3] = 11'd2;
        for (int i = 0; i < 4; i++) begin
            in_col0 = c0[i];
            in_col1 = c1[i];
            @(posedge clk);
            #1;
            checks++;
            if (comp_out !== exp_v[i]) begin
                errors++;
                $display("FAIL pattern_%0d: got %0d expected %0d", i, comp_out, exp_v[i]);
            end
        end
        // A few hand-computed mixed patterns.
        in_col0 = '0; in_col0[0] = 1'b1; in_col0[100] = 1'b1; in_col0[511] = 1'b1;
        in_col1 = '0; in_col1[7:0] = 8'hFF;
        @(posedge clk);
        #1;
        checks++;
        if (comp_out !== 11'd19) begin
            errors++;
            $display("FAIL pattern_mixed: got %0d expected 19", comp_out);
        end
        in_col0 = {256'd0, {256{1'b1}}};
        in_col1 = {{128{4'b0101}}};
        @(posedge clk);
        #1;
        checks++;
        if (comp_out !== 11'd768) begin
            errors++;
            $display("FAIL pattern_half: got %0d expected 768", comp_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [511:0] c0 [3];
        logic [511:0] c1 [3];
        logic [10:0]  exp_v [3];
        c0[0] = '0; c1[0] = '0; exp_v[0] = 11'd0;
        c0[1] = '1; c1[1] = '1; exp_v[1] = 11'd1536;
        c0[2] = '0; c0[2][0] = 1'b1; c1[2] = '0; exp_v[2] = 11'd1;
        in_col0 = c0[0];
        in_col1 = c1[0];
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (comp_out !== exp_v[i]) begin
                errors++;
                $display("FAIL b2b_%0d: got %0d expected %0d", i, comp_out, exp_v[i]);
            end
            if (i < 2) begin
                in_col0 = c0[i+1];
                in_col1 = c1[i+1];
                #2;
                checks++;
                if (comp_out !== exp_v[i]) begin
                    errors++;
                    $display("FAIL b2b_hold_%0d: got %0d expected %0d", i, comp_out, exp_v[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [10:0] exp_v;
        for (int i = 0; i < 20000; i++) begin
            if (i == 10000) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if (comp_out !== 11'd0) begin
                    errors++;
                    $display("FAIL rand_reset_drop: got %0d expected 0", comp_out);
                end
                @(posedge clk);
                #3;
                rst_n = 1'b1;
            end
            in_col0 = rnd512();
            in_col1 = rnd512();
            exp_v   = model(in_col0, in_col1);
            @(posedge clk);
            #1;
            checks++;
            if (comp_out !== exp_v) begin
                errors++;
                if (errors < 20)
                    $display("FAIL rand_%0d: got %0d expected %0d", i, comp_out, exp_v);
            end
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        rst_n   = 1'b0;
        in_col0 = '0;
        in_col1 = '0;
        #12;
        test_reset();
        test_patterns();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
